// File: rtl/mem_bus_pkg.sv
// Shared encodings, widths and FSM states for the C2/A2/D2 line-bus arbiter.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        C2_NOP        = 2'd0,
        C2_RESPONSE   = 2'd1,
        C2_READ_LINE  = 2'd2,
        C2_WRITE_LINE = 2'd3
    } c2_cmd_e;

    localparam int LINE_BYTES = 16;
    localparam int BEATS      = 8;
    localparam int ADDR2_W    = 15;
    localparam int DATA2_W    = 16;
    localparam int LINE_W     = LINE_BYTES * 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WDATA,
        ST_WAIT_RESP,
        ST_RDATA,
        ST_DONE
    } arb_state_e;

    // Beat i carries line bytes 2i (low half) and 2i+1 (high half).
    function automatic logic [DATA2_W-1:0] line_beat(input logic [LINE_W-1:0] line,
                                                      input logic [2:0]        idx);
        line_beat = line[{idx, 4'b0000} +: DATA2_W];
    endfunction

endpackage

// File: rtl/mem_bus_rr_arb.sv
// Two-way round-robin grant; last_grant resets to 1 so requester 0 wins first.
module mem_bus_rr_arb (
    input  logic       clk,
    input  logic       rst_n_i,
    input  logic [1:0] req_valid_i,
    input  logic       grant_en_i,
    output logic       grant_valid_o,
    output logic       grant_idx_o
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        grant_valid_o = |req_valid_i;
        grant_idx_o   = (req_valid_i == 2'b11) ? ~last_grant_q : req_valid_i[1];
        last_grant_d  = last_grant_q;
        if (grant_en_i && grant_valid_o) begin
            last_grant_d = grant_idx_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the C2/A2/D2 line bus between two requesters and runs command,
// burst and response phases for 16-byte line reads and writes.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int TIMEOUT_CYC = 512,
    parameter int NREQ        = 2
) (
    input  logic               clk,
    input  logic               RESET,
    input  logic [1:0]         req_valid,
    input  logic [1:0]         req_write,
    input  logic [ADDR2_W-1:0] req_addr0,
    input  logic [ADDR2_W-1:0] req_addr1,
    input  logic [LINE_W-1:0]  req_wline0,
    input  logic [LINE_W-1:0]  req_wline1,
    output logic [1:0]         done,
    output logic               err,
    output logic [LINE_W-1:0]  rd_line,
    output logic               busy,
    output logic [ADDR2_W-1:0] A2,
    inout  wire  [1:0]         C2,
    inout  wire  [DATA2_W-1:0] D2
);

    localparam int GRANT_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TMO_W   = $clog2(TIMEOUT_CYC + 1);

    arb_state_e         state_q, state_d;
    logic [GRANT_W-1:0] grant_q, grant_d;
    logic               write_q, write_d;
    logic [ADDR2_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0]  wline_q, wline_d;
    logic [LINE_W-1:0]  rbuf_q, rbuf_d;
    logic [LINE_W-1:0]  rd_line_q, rd_line_d;
    logic               err_q, err_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;

    logic               grant_valid;
    logic               grant_idx;
    logic               c2_oe, d2_oe;
    logic [1:0]         c2_out;
    logic [DATA2_W-1:0] d2_out;

    mem_bus_rr_arb u_rr_arb (
        .clk           (clk),
        .rst_n_i       (RESET),
        .req_valid_i   (req_valid),
        .grant_en_i    (state_q == ST_IDLE),
        .grant_valid_o (grant_valid),
        .grant_idx_o   (grant_idx)
    );

    // The bus is only ever driven in CMD/WDATA; the memory owns it otherwise.
    assign C2 = c2_oe ? c2_out : 'z;
    assign D2 = d2_oe ? d2_out : 'z;

    assign done    = (state_q == ST_DONE) ? (grant_q[0] ? 2'b10 : 2'b01) : 2'b00;
    assign err     = err_q;
    assign rd_line = rd_line_q;
    assign busy    = (state_q != ST_IDLE);
    assign A2      = (state_q == ST_IDLE) ? '0 : addr_q;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wline_d   = wline_q;
        rbuf_d    = rbuf_q;
        rd_line_d = rd_line_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        tmo_d     = '0;
        c2_oe     = 1'b0;
        d2_oe     = 1'b0;
        c2_out    = C2_NOP;
        d2_out    = line_beat(wline_q, cnt_q);

        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    grant_d = grant_idx;
                    write_d = req_write[grant_idx];
                    addr_d  = grant_idx ? req_addr1 : req_addr0;
                    wline_d = grant_idx ? req_wline1 : req_wline0;
                    cnt_d   = 3'd0;
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                c2_oe   = 1'b1;
                c2_out  = write_q ? C2_WRITE_LINE : C2_READ_LINE;
                d2_oe   = write_q;
                cnt_d   = 3'd1;
                state_d = write_q ? ST_WDATA : ST_WAIT_RESP;
            end
            ST_WDATA: begin
                c2_oe = 1'b1;
                d2_oe = 1'b1;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = ST_WAIT_RESP;
                end
            end
            ST_WAIT_RESP: begin
                tmo_d = tmo_q + 1'b1;
                if (C2 == C2_RESPONSE) begin
                    err_d = 1'b0;
                    if (write_q) begin
                        state_d = ST_DONE;
                    end else begin
                        rbuf_d[DATA2_W-1:0] = D2;
                        cnt_d               = 3'd1;
                        state_d             = ST_RDATA;
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    err_d = 1'b1;
                    if (!write_q) begin
                        rd_line_d = '0;
                    end
                    state_d = ST_DONE;
                end
            end
            // Beats 1..7 arrive on consecutive edges regardless of C2.
            ST_RDATA: begin
                rbuf_d[{cnt_q, 4'b0000} +: DATA2_W] = D2;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    rd_line_d = rbuf_d;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wline_q   <= '0;
            rbuf_q    <= '0;
            rd_line_q <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wline_q   <= wline_d;
            rbuf_q    <= rbuf_d;
            rd_line_q <= rd_line_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a procedural memory model answers on
// C2/D2 and every expectation is written out by hand.
module tb_mem_bus_arbiter;
    import mem_bus_pkg::*;

    localparam int TMO = 16;

    logic         clk = 1'b0;
    logic         RESET = 1'b1;
    logic [1:0]   req_valid = '0;
    logic [1:0]   req_write = '0;
    logic [14:0]  req_addr0 = '0;
    logic [14:0]  req_addr1 = '0;
    logic [127:0] req_wline0 = '0;
    logic [127:0] req_wline1 = '0;
    logic [1:0]   done;
    logic         err;
    logic [127:0] rd_line;
    logic         busy;
    logic [14:0]  A2;
    wire  [1:0]   C2;
    wire  [15:0]  D2;

    logic         mem_c2_en = 1'b0;
    logic         mem_d2_en = 1'b0;
    logic [1:0]   mem_c2 = '0;
    logic [15:0]  mem_d2 = '0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    assign C2 = mem_c2_en ? mem_c2 : 2'bzz;
    assign D2 = mem_d2_en ? mem_d2 : 16'hzzzz;

    mem_bus_arbiter #(.TIMEOUT_CYC(TMO), .NREQ(2)) dut (
        .clk        (clk),
        .RESET      (RESET),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr0  (req_addr0),
        .req_addr1  (req_addr1),
        .req_wline0 (req_wline0),
        .req_wline1 (req_wline1),
        .done       (done),
        .err        (err),
        .rd_line    (rd_line),
        .busy       (busy),
        .A2         (A2),
        .C2         (C2),
        .D2         (D2)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // A released net reads as Z in a 4-state simulator and 0 in a 2-state one.
    function automatic logic c2_rel();
        return $isunknown(C2) || (C2 == 2'b00);
    endfunction

    function automatic logic d2_rel();
        return $isunknown(D2) || (D2 == 16'h0000);
    endfunction

    function automatic logic [127:0] mk_line(input logic [7:0] base);
        logic [127:0] l;
        for (int k = 0; k < 16; k++) l[8*k +: 8] = base + 8'(k);
        return l;
    endfunction

    // Bus-ownership monitor: C2 carries a command in CMD, NOP in WDATA,
    // and is released in every other state.
    always @(negedge clk) begin
        if (RESET) begin
            case (dut.state_q)
                ST_CMD:   check("mon_cmd", (C2 == 2'd2) || (C2 == 2'd3), 1'b1);
                ST_WDATA: check("mon_wdata", {C2, $isunknown(D2)}, 3'b000);
                default:  if (!mem_c2_en) check("mon_rel", c2_rel() && (mem_d2_en || d2_rel()), 1'b1);
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cmd(output int n);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            n++;
            if ((C2 == 2'd2) || (C2 == 2'd3)) break;
        end
    endtask

    // Entered in the CMD cycle of a write.
    task automatic run_write(input string tag, input logic [14:0] addr, input logic [127:0] line,
                             input int resp_wait, input logic [1:0] exp_done);
        check({tag, "_c2"}, C2, 2'd3);
        check({tag, "_a2"}, A2, addr);
        check({tag, "_b0"}, D2, line[15:0]);
        for (int i = 1; i < 8; i++) begin
            @(posedge clk); #1;
            check($sformatf("%s_b%0d", tag, i), D2, line[i*16 +: 16]);
        end
        @(posedge clk); #1;
        check({tag, "_a2w"}, A2, addr);
        check({tag, "_pre"}, done, 2'b00);
        repeat (resp_wait - 1) @(posedge clk);
        if (resp_wait > 1) #1;
        mem_c2 = 2'd1;
        mem_c2_en = 1'b1;
        @(posedge clk); #1;
        mem_c2_en = 1'b0;
        check({tag, "_done"}, done, exp_done);
        check({tag, "_err"}, err, 1'b0);
        check({tag, "_busy"}, busy, 1'b1);
    endtask

    // Entered in the CMD cycle of a read; memory answers after wait_cyc idle cycles.
    task automatic run_read(input string tag, input logic [14:0] addr, input int wait_cyc,
                            input logic [127:0] line, input logic [1:0] exp_done);
        int cmd_cyc;
        check({tag, "_c2"}, C2, 2'd2);
        check({tag, "_a2"}, A2, addr);
        cmd_cyc = cyc;
        repeat (1 + wait_cyc) @(posedge clk);
        #1;
        check({tag, "_pre"}, done, 2'b00);
        mem_c2 = 2'd1;
        mem_c2_en = 1'b1;
        mem_d2 = line[15:0];
        mem_d2_en = 1'b1;
        for (int i = 1; i < 8; i++) begin
            @(posedge clk); #1;
            mem_c2_en = 1'b0;
            mem_d2 = line[i*16 +: 16];
        end
        @(posedge clk); #1;
        mem_d2_en = 1'b0;
        check({tag, "_done"}, done, exp_done);
        check({tag, "_err"}, err, 1'b0);
        check({tag, "_line"}, rd_line, line);
        check({tag, "_lat"}, cyc - cmd_cyc + 1, 1 + wait_cyc + 8 + 1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int cmd_cyc;
        logic [127:0] line40, line60, line00, line30, linea0;
        line40 = mk_line(8'h40);
        line60 = mk_line(8'h60);
        line00 = mk_line(8'h00);
        line30 = mk_line(8'h30);
        linea0 = mk_line(8'hA0);

        #2 RESET = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_done", done, 2'b00);
        check("rst_err", err, 1'b0);
        check("rst_line", rd_line, 128'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_a2", A2, 15'h0);
        check("rst_bus", c2_rel() && d2_rel(), 1'b1);
        #2 RESET = 1'b1;

        // Simultaneous requests: 0 first, then 1, and again 0 first.
        req_write = 2'b11;
        req_addr0 = 15'h0123;
        req_addr1 = 15'h0456;
        req_wline0 = line40;
        req_wline1 = line60;
        for (int rep = 0; rep < 2; rep++) begin
            req_valid = 2'b11;
            wait_cmd(n);
            check($sformatf("sim%0d_gap0", rep), n, (rep == 0) ? 1 : 2);
            req_valid[0] = 1'b0;
            run_write($sformatf("sim%0d_r0", rep), 15'h0123, line40, 2, 2'b01);
            wait_cmd(n);
            check($sformatf("sim%0d_gap1", rep), n, 2);
            req_valid[1] = 1'b0;
            run_write($sformatf("sim%0d_r1", rep), 15'h0456, line60, 2, 2'b10);
        end

        // Fast read on requester 0.
        req_write = 2'b00;
        req_addr0 = 15'h0012;
        req_valid = 2'b01;
        wait_cmd(n);
        req_valid = 2'b00;
        run_read("rd", 15'h0012, 3, line00, 2'b01);

        // Write burst on requester 1 to the top address.
        req_write = 2'b10;
        req_addr1 = 15'h7FFF;
        req_wline1 = linea0;
        req_valid = 2'b10;
        wait_cmd(n);
        req_valid = 2'b00;
        run_write("wr", 15'h7FFF, linea0, 10, 2'b10);
        @(posedge clk); #1;
        check("wr_idle", busy, 1'b0);

        // Silent memory: read must abort with err after TMO wait cycles.
        req_write = 2'b00;
        req_addr0 = 15'h0055;
        req_valid = 2'b01;
        wait_cmd(n);
        req_valid = 2'b00;
        cmd_cyc = cyc;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done != 2'b00) break;
        end
        check("tmo_lat", cyc - cmd_cyc, TMO + 1);
        check("tmo_done", done, 2'b01);
        check("tmo_err", err, 1'b1);
        check("tmo_line", rd_line, 128'h0);

        // Reset during RDATA beat 4.
        req_addr1 = 15'h0AAA;
        req_valid = 2'b10;
        wait_cmd(n);
        req_valid = 2'b00;
        check("rrst_a2", A2, 15'h0AAA);
        @(posedge clk); #1;
        mem_c2 = 2'd1;
        mem_c2_en = 1'b1;
        mem_d2 = line60[15:0];
        mem_d2_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            mem_c2_en = 1'b0;
            mem_d2 = line60[i*16 +: 16];
        end
        #3;
        RESET = 1'b0;
        mem_d2_en = 1'b0;
        #1;
        check("rrst_busy", busy, 1'b0);
        check("rrst_done", done, 2'b00);
        check("rrst_line", rd_line, 128'h0);
        check("rrst_bus", c2_rel() && d2_rel(), 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check($sformatf("rrst_nodone%0d", i), done, 2'b00);
        end
        #2 RESET = 1'b1;

        // Next request after reset runs normally.
        req_addr0 = 15'h0012;
        req_valid = 2'b01;
        wait_cmd(n);
        check("post_gap", n, 1);
        req_valid = 2'b00;
        run_read("post", 15'h0012, 1, line30, 2'b01);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
